// File: rtl/pulse_event_arbiter_if.sv
// pulse_event_arbiter_if: pulse inputs, event slot handshake and status flags
interface pulse_event_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int TS_W   = 16
);
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] pulse_in;
  logic [NUM_CH-1:0] ch_en;
  logic              evt_ready;
  logic              ovf_clr;
  logic              evt_valid;
  logic [CH_W-1:0]   evt_ch;
  logic [TS_W-1:0]   evt_ts;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ovf;
  modport master (
    output pulse_in, ch_en, evt_ready, ovf_clr,
    input  evt_valid, evt_ch, evt_ts, pending, ovf
  );
  modport slave (
    input  pulse_in, ch_en, evt_ready, ovf_clr,
    output evt_valid, evt_ch, evt_ts, pending, ovf
  );
endinterface

// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter: latches channel pulses and issues them round-robin through one event slot; PULSE_ARB_TIMESTAMP_EN adds timestamps
module pulse_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int TS_W   = 16
) (
  input logic clk,
  input logic rst,
  pulse_event_arbiter_if.slave bus
);
  localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] pending_q, pending_d, ovf_q, ovf_d, elig, hit, won;
  logic [CH_W-1:0]   last_q, evt_ch_q, win;
  logic              evt_valid_q, load, grant, found;
  assign elig  = pending_q & bus.ch_en;
  assign hit   = bus.pulse_in & bus.ch_en;
  assign load  = !evt_valid_q || bus.evt_ready;
  assign grant = load && found;
  assign won   = grant ? (NUM_CH'(1) << win) : '0;
  // a pulse arriving on the edge its channel is granted re-arms the channel rather than overflowing
  assign pending_d = bus.ch_en & ((pending_q & ~won) | hit);
  assign ovf_d     = (ovf_q & ~{NUM_CH{bus.ovf_clr}}) | (hit & pending_q & ~won);
  // round-robin pick: lowest eligible channel above last_grant, else wrap to lowest eligible overall
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) if (elig[c]) begin found = 1'b1; win = CH_W'(c); end
    for (int c = NUM_CH - 1; c >= 0; c--) if (elig[c] && c > int'(last_q)) win = CH_W'(c);
  end
  // pending/overflow flags and the event slot; last_grant only moves on a load
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      ovf_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      if (load) evt_valid_q <= found;
      if (grant) begin
        evt_ch_q <= win;
        last_q   <= win;
      end
    end
  end
`ifdef PULSE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_q, evt_ts_q;
  logic [TS_W-1:0]   stamp_q [NUM_CH];
  logic [NUM_CH-1:0] cap;
  assign cap = hit & (~pending_q | won);
  // free-running counter; a channel stamps when it newly latches, overflows keep the first stamp
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q     <= '0;
      evt_ts_q <= '0;
      for (int i = 0; i < NUM_CH; i++) stamp_q[i] <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (grant) evt_ts_q <= stamp_q[win];
      for (int i = 0; i < NUM_CH; i++) if (cap[i]) stamp_q[i] <= ts_q;
    end
  end
  assign bus.evt_ts = evt_ts_q;
`else
  assign bus.evt_ts = '0;
`endif
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_ch    = evt_ch_q;
  assign bus.pending   = pending_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pulse_event_arbiter.sv
// tb_pulse_event_arbiter: directed scenarios checked against a per-cycle behavioural model plus literal expectations
module tb_pulse_event_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  pulse_event_arbiter_if #(.NUM_CH(4), .TS_W(16)) bus ();
  pulse_event_arbiter #(.NUM_CH(4), .TS_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [3:0] m_pend = '0, m_ovf = '0;
  bit         m_val = 1'b0;
  int         m_ch = 0, m_evts = 0, m_last = 3, m_cnt = 0;
  int         m_stamp [4] = '{0, 0, 0, 0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic model_step();
    logic [3:0] p, e, np, nov, stampm;
    int g, c;
    if (rst) begin
      m_pend = '0; m_ovf = '0; m_val = 1'b0; m_ch = 0; m_evts = 0; m_last = 3; m_cnt = 0;
      for (int i = 0; i < 4; i++) m_stamp[i] = 0;
    end else begin
      p = bus.pulse_in; e = bus.ch_en; g = -1; stampm = '0;
      if (!m_val || bus.evt_ready)
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (g < 0 && m_pend[c] && e[c]) g = c;
        end
      nov = bus.ovf_clr ? 4'b0 : m_ovf;
      for (int i = 0; i < 4; i++) begin
        if (!e[i]) np[i] = 1'b0;
        else if (p[i]) begin
          np[i] = 1'b1;
          if (m_pend[i] && i != g) nov[i] = 1'b1;
          else stampm[i] = 1'b1;
        end else np[i] = m_pend[i] && i != g;
      end
      if (!m_val || bus.evt_ready) begin
        if (g >= 0) begin m_val = 1'b1; m_ch = g; m_evts = m_stamp[g]; m_last = g; end
        else m_val = 1'b0;
      end
      for (int i = 0; i < 4; i++) if (stampm[i]) m_stamp[i] = m_cnt;
      m_pend = np; m_ovf = nov; m_cnt = (m_cnt + 1) & 32'hFFFF;
    end
  endtask
  always @(posedge clk) begin
    model_step();
    #1;
    chk("model_valid", 32'(bus.evt_valid), 32'(m_val));
    chk("model_pending", 32'(bus.pending), 32'(m_pend));
    chk("model_ovf", 32'(bus.ovf), 32'(m_ovf));
    if (m_val) begin
      chk("model_ch", 32'(bus.evt_ch), 32'(m_ch));
`ifdef PULSE_ARB_TIMESTAMP_EN
      chk("model_ts", 32'(bus.evt_ts), 32'(m_evts));
`else
      chk("model_ts", 32'(bus.evt_ts), 32'h0);
`endif
    end
  end
  task automatic step(input logic [3:0] p, input logic [3:0] e, input logic r, input logic c);
    bus.pulse_in = p; bus.ch_en = e; bus.evt_ready = r; bus.ovf_clr = c;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    rst = 1'b0;
  endtask
  task automatic slot(input string name, input logic v, input logic [1:0] ch);
    chk({name, "_valid"}, 32'(bus.evt_valid), 32'(v));
    if (v) chk({name, "_ch"}, 32'(bus.evt_ch), 32'(ch));
  endtask
  initial begin
    bus.pulse_in = '0; bus.ch_en = '0; bus.evt_ready = 1'b0; bus.ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.evt_valid), 0);
    chk("rst_ch", 32'(bus.evt_ch), 0);
    chk("rst_ts", 32'(bus.evt_ts), 0);
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    rst = 1'b0;
    step(4'b0100, 4'b1111, 1'b1, 1'b0);
    chk("single_pend", 32'(bus.pending), 32'h4);
    slot("single_t", 1'b0, 2'd0);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    slot("single_t1", 1'b1, 2'd2);
    chk("single_pend0", 32'(bus.pending), 0);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    slot("single_end", 1'b0, 2'd0);
    do_reset();
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    chk("all_pend", 32'(bus.pending), 32'hF);
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 4'b1111, 1'b1, 1'b0);
      slot("rr_seq", 1'b1, 2'(i));
    end
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    slot("rr_end", 1'b0, 2'd0);
    do_reset();
    step(4'b0010, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
    slot("hold_load", 1'b1, 2'd1);
    step(4'b0010, 4'b1111, 1'b0, 1'b0);
    chk("hold_pend", 32'(bus.pending), 32'h2);
    chk("hold_noovf", 32'(bus.ovf), 0);
    step(4'b0010, 4'b1111, 1'b0, 1'b0);
    chk("ovf_set", 32'(bus.ovf), 32'h2);
    chk("ovf_pend", 32'(bus.pending), 32'h2);
    slot("ovf_hold", 1'b1, 2'd1);
    step(4'b0000, 4'b1111, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.ovf), 0);
    step(4'b0010, 4'b1111, 1'b0, 1'b1);
    chk("ovf_clr_race", 32'(bus.ovf), 32'h2);
    step(4'b0000, 4'b1111, 1'b1, 1'b1);
    chk("ovf_drain_pend", 32'(bus.pending), 0);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    slot("ovf_drain_end", 1'b0, 2'd0);
    do_reset();
    step(4'b0001, 4'b1110, 1'b1, 1'b0);
    chk("mask_pend", 32'(bus.pending), 0);
    step(4'b0000, 4'b1110, 1'b1, 1'b0);
    slot("mask_none", 1'b0, 2'd0);
    step(4'b0100, 4'b1111, 1'b1, 1'b0);
    chk("mask2_pend", 32'(bus.pending), 32'h4);
    step(4'b0000, 4'b1011, 1'b1, 1'b0);
    chk("mask2_clear", 32'(bus.pending), 0);
    slot("mask2_none", 1'b0, 2'd0);
    do_reset();
    step(4'b0001, 4'b1111, 1'b1, 1'b0);
    step(4'b0001, 4'b1111, 1'b1, 1'b0);
    slot("regrant_a", 1'b1, 2'd0);
    chk("regrant_pend", 32'(bus.pending), 32'h1);
    chk("regrant_ovf", 32'(bus.ovf), 0);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    slot("regrant_b", 1'b1, 2'd0);
    do_reset();
    step(4'b0001, 4'b1111, 1'b0, 1'b0);
    step(4'b0110, 4'b1111, 1'b0, 1'b0);
    slot("rstmid_busy", 1'b1, 2'd0);
    chk("rstmid_pend", 32'(bus.pending), 32'h6);
    rst = 1'b1;
    step(4'b1000, 4'b1111, 1'b0, 1'b0);
    chk("rstmid_valid", 32'(bus.evt_valid), 0);
    chk("rstmid_pend0", 32'(bus.pending), 0);
    chk("rstmid_ch", 32'(bus.evt_ch), 0);
    rst = 1'b0;
    step(4'b1000, 4'b1111, 1'b1, 1'b0);
    slot("rstmid_t", 1'b0, 2'd0);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    slot("rstmid_t1", 1'b1, 2'd3);
`ifdef PULSE_ARB_TIMESTAMP_EN
    for (int i = 0; i < 70000 && m_cnt != 32'hFFFD; i++) step(4'b0000, 4'b1111, 1'b1, 1'b0);
    chk("ts_reach", 32'(m_cnt), 32'hFFFD);
    step(4'b0001, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b0, 1'b0);
    step(4'b1000, 4'b1111, 1'b0, 1'b0);
    repeat (4) step(4'b0000, 4'b1111, 1'b0, 1'b0);
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    slot("ts_wrap", 1'b1, 2'd3);
    chk("ts_wrap_val", 32'(bus.evt_ts), 32'hFFFF);
`endif
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_event_arbiter.md
PULSE_EVENT_ARBITER -- requirements
Module: pulse_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of pulse channels; legal range 2..16.
REQ-002 Parameter TS_W, default 16, timestamp width in bits.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pulse_in  input  NUM_CH  one-cycle event pulses, one bit per channel, from upstream debounce/edge detectors.
REQ-006 ch_en  input  NUM_CH  per-channel enable; 0 masks the channel.
REQ-007 evt_ready  input  1  downstream accepts the current event.
REQ-008 ovf_clr  input  1  clears all overflow flags.
REQ-009 evt_valid  output  1  event slot holds a valid event.
REQ-010 evt_ch  output  CH_W=max(1,clog2(NUM_CH))  channel index of the current event.
REQ-011 evt_ts  output  TS_W  timestamp of the current event.
REQ-012 pending  output  NUM_CH  per-channel latched-but-not-issued flags.
REQ-013 ovf  output  NUM_CH  sticky per-channel overflow flags.

Function
REQ-014 pulse_in[i] high with ch_en[i]=1 at edge t SHALL set pending[i] after edge t.
REQ-015 On any edge where ch_en[i]=0, pending[i] SHALL clear and pulse_in[i] SHALL be ignored.
REQ-016 The output slot SHALL be loadable on an edge when evt_valid=0 or evt_ready=1.
REQ-017 On a loadable edge with at least one pending bit set, the slot SHALL load the winning channel: evt_valid=1, evt_ch=winner, and pending[winner] cleared.
REQ-018 On a loadable edge with no pending bit set, evt_valid SHALL go to 0.
REQ-019 When evt_valid=1 and evt_ready=0, evt_ch and evt_ts SHALL hold stable.
REQ-020 Arbitration SHALL be round-robin: search starts at last_grant+1 and wraps modulo NUM_CH.
REQ-021 last_grant SHALL update only when a slot load occurs.
REQ-022 Minimum latency SHALL be 2 edges: pulse sampled at edge t gives evt_valid=1 after edge t+1.
REQ-023 A pulse on channel i while pending[i]=1 and i is not granted on that edge SHALL set ovf[i]; pending[i] stays 1.
REQ-024 A pulse on channel i on the same edge that grants i SHALL leave pending[i]=1 with no overflow.
REQ-025 ovf_clr=1 SHALL clear all ovf bits; an overflow on the same edge SHALL win for that bit.
REQ-026 Sustained back-to-back throughput SHALL be one event per cycle while evt_ready=1.

Reset
REQ-027 While rst=1 at an edge, the following SHALL clear: pending=0, ovf=0, evt_valid=0, evt_ch=0, evt_ts=0, timestamp counter=0, last_grant=NUM_CH-1 (channel 0 has first priority).
REQ-028 Pulses coinciding with rst=1 SHALL be discarded.
REQ-029 Asserting rst mid-handshake SHALL drop the in-flight event without a further evt_valid.

Configuration
REQ-030 Macro PULSE_ARB_TIMESTAMP_EN compiles in the timestamp feature.
REQ-031 With PULSE_ARB_TIMESTAMP_EN defined:
- A free-running TS_W-bit counter increments every non-reset cycle and wraps to 0.
- Each channel stores the counter value on the edge its pending bit sets from 0.
- An overflow SHALL NOT overwrite the stored value.
- evt_ts carries the stored value of the granted channel.
REQ-032 Without PULSE_ARB_TIMESTAMP_EN, the counter and per-channel storage SHALL be absent and evt_ts SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-033 Reset, then pulse_in=4'b0100 for 1 cycle with evt_ready=1 -> evt_valid=1, evt_ch=2 two edges later for exactly 1 cycle; pending returns to 0.
REQ-034 pulse_in=4'b1111 in 1 cycle with evt_ready=1 -> evt_ch sequence 0,1,2,3 on consecutive cycles, then evt_valid=0.
REQ-035 evt_ready=0 with channel 1 in the slot, then a second pulse on 1 and a third pulse on 1 -> pending[1]=1, ovf[1]=1, evt_ch held at 1; ovf_clr pulse -> ovf=0.
REQ-036 ch_en=4'b1110, pulse_in=4'b0001 -> no event and pending[0] stays 0; clearing ch_en[2] while pending[2]=1 -> pending[2]=0 and no event for channel 2.
REQ-037 With PULSE_ARB_TIMESTAMP_EN, pulse ch3 with counter at 16'hFFFF, delay grant by 5 cycles -> evt_ts=16'hFFFF; counter wrapped to 4.
REQ-038 rst=1 while evt_valid=1, evt_ready=0 and pending=4'b0110 -> after the edge all outputs are 0, and the next pulse on channel 3 is granted in 2 edges.
